// File: rtl/conv_window_shifter.sv
// Streams k x k convolution windows out of three snapshotted row registers.
module conv_window_shifter #(
    parameter int unsigned SHIFT_REGS_NUM = 70,
    parameter int unsigned PIX_W          = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [3:0]                      k,
    input  logic [3:0]                      s,
    input  logic [7:0]                      win_cols,
    input  logic                            shift_start,
    input  logic [SHIFT_REGS_NUM*PIX_W-1:0] row_regs_1,
    input  logic [SHIFT_REGS_NUM*PIX_W-1:0] row_regs_2,
    input  logic [SHIFT_REGS_NUM*PIX_W-1:0] row_regs_3,
    input  logic                            win_ready,
    output logic                            win_valid,
    output logic [9*PIX_W-1:0]              win_data,
    output logic [7:0]                      win_col_idx,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned ROW_W = SHIFT_REGS_NUM * PIX_W;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   shadow_q [3];
    logic [ROW_W-1:0]   shadow_d [3];
    logic               k3_q, k3_d;
    logic               s2_q, s2_d;
    logic [CNT_W-1:0]   cols_q, cols_d;
    logic [CNT_W-1:0]   n_win_q, n_win_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   win_col_idx_q, win_col_idx_d;
    logic               win_valid_q, win_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic [CNT_W-1:0]   kk;
    logic [CNT_W-1:0]   n_win_calc;
    logic [CNT_W-1:0]   cols_clamped;

    assign accept       = win_valid_q & win_ready;
    assign kk           = k3_q ? CNT_W'(3) : CNT_W'(1);
    assign n_win_calc   = (cols_q < kk) ? '0 : (((cols_q - kk) >> s2_q) + CNT_W'(1));
    assign cols_clamped = (win_cols > CNT_W'(SHIFT_REGS_NUM)) ? CNT_W'(SHIFT_REGS_NUM) : win_cols;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start requests outside IDLE are ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (shift_start) state_d = ST_LOAD;
            ST_LOAD:  state_d = (n_win_calc == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (accept && (win_cnt_q == (n_win_q - CNT_W'(1)))) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered control outputs decoded from the upcoming state
    always_comb begin
        win_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        unique case (state_d)
            ST_LOAD:  busy_d = 1'b1;
            ST_SHIFT: begin
                busy_d      = 1'b1;
                win_valid_d = 1'b1;
            end
            ST_DONE:  done_d = 1'b1;
            default:  ;
        endcase
    end

    // Capture, window counting and shadow shifting
    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            shadow_d[r] = shadow_q[r];
        end
        k3_d          = k3_q;
        s2_d          = s2_q;
        cols_d        = cols_q;
        n_win_d       = n_win_q;
        win_cnt_d     = win_cnt_q;
        win_col_idx_d = win_col_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (shift_start) begin
                    shadow_d[0] = row_regs_1;
                    shadow_d[1] = row_regs_2;
                    shadow_d[2] = row_regs_3;
                    k3_d        = (k == 4'd3);
                    s2_d        = (s == 4'd2);
                    cols_d      = cols_clamped;
                end
            end
            ST_LOAD: begin
                n_win_d       = n_win_calc;
                win_cnt_d     = '0;
                win_col_idx_d = '0;
            end
            ST_SHIFT: begin
                if (accept) begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        shadow_d[r] = shadow_q[r] >> (s2_q ? 2 * PIX_W : PIX_W);
                    end
                    win_cnt_d     = win_cnt_q + CNT_W'(1);
                    win_col_idx_d = win_col_idx_q + (s2_q ? CNT_W'(2) : CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

    // Datapath and output flops
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < 3; r++) begin
                shadow_q[r] <= '0;
            end
            k3_q          <= 1'b0;
            s2_q          <= 1'b0;
            cols_q        <= '0;
            n_win_q       <= '0;
            win_cnt_q     <= '0;
            win_col_idx_q <= '0;
            win_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < 3; r++) begin
                shadow_q[r] <= shadow_d[r];
            end
            k3_q          <= k3_d;
            s2_q          <= s2_d;
            cols_q        <= cols_d;
            n_win_q       <= n_win_d;
            win_cnt_q     <= win_cnt_d;
            win_col_idx_q <= win_col_idx_d;
            win_valid_q   <= win_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Window view: leftmost kk bytes of each shadow row, unused columns zero
    always_comb begin
        win_data = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                if ((c == 0) || k3_q) begin
                    win_data[(r*3+c)*PIX_W +: PIX_W] = shadow_q[r][c*PIX_W +: PIX_W];
                end
            end
        end
    end

    assign win_valid   = win_valid_q;
    assign win_col_idx = win_col_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv_window_shifter.sv
// Randomized bench for conv_window_shifter against a per-window array model.
module tb_conv_window_shifter;

    localparam int unsigned N  = 70;
    localparam int unsigned PW = 8;

    logic            clk;
    logic            reset;
    logic [3:0]      k;
    logic [3:0]      s;
    logic [7:0]      win_cols;
    logic            shift_start;
    logic [N*PW-1:0] row_regs_1;
    logic [N*PW-1:0] row_regs_2;
    logic [N*PW-1:0] row_regs_3;
    logic            win_ready;
    logic            win_valid;
    logic [9*PW-1:0] win_data;
    logic [7:0]      win_col_idx;
    logic            busy;
    logic            done;

    int errs   = 0;
    int checks = 0;

    logic [7:0] rows [3][N];
    int m_kk;
    int m_st;

    conv_window_shifter #(.SHIFT_REGS_NUM(N), .PIX_W(PW)) dut (
        .clk(clk), .reset(reset), .k(k), .s(s), .win_cols(win_cols),
        .shift_start(shift_start), .row_regs_1(row_regs_1), .row_regs_2(row_regs_2),
        .row_regs_3(row_regs_3), .win_ready(win_ready), .win_valid(win_valid),
        .win_data(win_data), .win_col_idx(win_col_idx), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*PW-1:0] pack_row(input int r);
        logic [N*PW-1:0] v;
        for (int i = 0; i < N; i++) v[i*PW +: PW] = rows[r][i];
        return v;
    endfunction

    // Window j: column c of row r is pixel (j*stride + c) when c < kernel size
    function automatic logic [71:0] model_win(input int j);
        logic [71:0] w;
        int idx;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                idx = j * m_st + c;
                if (c < m_kk && idx < N) w[(r*3+c)*8 +: 8] = rows[r][idx];
            end
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full load/stream operation with optional reset or start injection
    task automatic run_op(input int kin, input int sin, input int cols_in, input int ready_pct,
                          input int pat, input int rst_win, input int inj_win, input bit inj_done);
        int cols, n, j, done_c;
        bit finished;
        bit injected;
        logic exp_valid, exp_busy;
        m_kk = (kin == 3) ? 3 : 1;
        m_st = (sin == 2) ? 2 : 1;
        cols = (cols_in > N) ? N : cols_in;
        n    = (cols < m_kk) ? 0 : ((cols - m_kk) / m_st) + 1;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++)
                rows[r][i] = (pat == 0) ? 8'(i + 80 * r) : 8'($urandom_range(255));
        k           = 4'(kin);
        s           = 4'(sin);
        win_cols    = 8'(cols_in);
        row_regs_1  = pack_row(0);
        row_regs_2  = pack_row(1);
        row_regs_3  = pack_row(2);
        shift_start = 1'b1;
        step();
        shift_start = 1'b0;
        k           = 4'($urandom_range(15));
        s           = 4'($urandom_range(15));
        win_cols    = 8'($urandom_range(255));
        row_regs_1  = {N{8'hA5}};
        row_regs_2  = {N{8'h5A}};
        row_regs_3  = {N{8'hC3}};
        j        = 0;
        done_c   = (n == 0) ? 2 : 1000000;
        finished = 1'b0;
        injected = 1'b0;
        for (int c = 1; c < 600; c++) begin
            exp_valid = (c >= 2) && (j < n);
            exp_busy  = (c == 1) || exp_valid;
            check("win_valid", 72'(win_valid), 72'(exp_valid));
            check("busy", 72'(busy), 72'(exp_busy));
            check("done", 72'(done), 72'(c == done_c));
            if (exp_valid) begin
                check("win_data", win_data, model_win(j));
                check("win_col_idx", 72'(win_col_idx), 72'(j * m_st));
            end
            if (c == done_c + 1) begin
                finished = 1'b1;
                break;
            end
            if (rst_win >= 0 && exp_valid && j == rst_win) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check("rst_valid", 72'(win_valid), 72'(0));
                check("rst_busy", 72'(busy), 72'(0));
                check("rst_done", 72'(done), 72'(0));
                check("rst_idx", 72'(win_col_idx), 72'(0));
                check("rst_data", win_data, 72'(0));
                for (int q = 0; q < 4; q++) begin
                    step();
                    check("post_rst_done", 72'(done), 72'(0));
                    check("post_rst_valid", 72'(win_valid), 72'(0));
                end
                return;
            end
            shift_start = 1'b0;
            if (inj_win >= 0 && exp_valid && j == inj_win && !injected) begin
                injected    = 1'b1;
                shift_start = 1'b1;
                k           = 4'd1;
                s           = 4'd2;
                win_cols    = 8'd10;
                row_regs_1  = {N{8'hFF}};
            end
            if (inj_done && c == done_c) shift_start = 1'b1;
            win_ready = ($urandom_range(99) < ready_pct);
            if (exp_valid && win_ready) begin
                j++;
                if (j == n) done_c = c + 1;
            end
            step();
        end
        shift_start = 1'b0;
        if (!finished) check("op_timeout", 72'(0), 72'(1));
        for (int q = 0; q < 2; q++) begin
            step();
            check("idle_busy", 72'(busy), 72'(0));
            check("idle_valid", 72'(win_valid), 72'(0));
            check("idle_done", 72'(done), 72'(0));
        end
    endtask

    initial begin
        reset       = 1'b1;
        k           = '0;
        s           = '0;
        win_cols    = '0;
        shift_start = 1'b0;
        row_regs_1  = '0;
        row_regs_2  = '0;
        row_regs_3  = '0;
        win_ready   = 1'b0;
        repeat (3) step();
        check("reset_valid", 72'(win_valid), 72'(0));
        check("reset_busy", 72'(busy), 72'(0));
        check("reset_done", 72'(done), 72'(0));
        check("reset_idx", 72'(win_col_idx), 72'(0));
        check("reset_data", win_data, 72'(0));
        reset = 1'b0;
        step();

        run_op(3, 1, 34, 100, 0, -1, -1, 1'b0);
        run_op(3, 2, 34, 100, 0, -1, -1, 1'b0);
        run_op(1, 1, 32, 100, 0, -1, -1, 1'b0);
        run_op(5, 3, 20, 100, 1, -1, -1, 1'b0);
        run_op(3, 1, 2,  100, 1, -1, -1, 1'b0);
        run_op(1, 1, 0,  100, 1, -1, -1, 1'b0);
        run_op(3, 1, 3,  100, 1, -1, -1, 1'b0);
        run_op(3, 1, 34, 50,  0, -1, -1, 1'b0);
        run_op(3, 1, 34, 100, 0, 10, -1, 1'b0);
        run_op(3, 1, 34, 100, 1, -1, 5,  1'b1);
        run_op(3, 2, 200, 70, 1, -1, -1, 1'b0);
        run_op(1, 1, 70, 100, 1, -1, -1, 1'b0);
        run_op(3, 1, 0,  100, 1, -1, -1, 1'b1);
        for (int t = 0; t < 6; t++) begin
            run_op(($urandom_range(1) == 1) ? 3 : 1, ($urandom_range(1) == 1) ? 2 : 1,
                   $urandom_range(80), $urandom_range(30, 100), 1, -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
